// File: rtl/adc_pkg.sv
// Shared definitions for the ADC frame packer: frame geometry, header word,
// output FSM state encoding, frame record layout and the checksum helper.
package adc_pkg;

  localparam int          NUM_CH           = 8;
  localparam int          FRAME_WORDS      = 11;  // header + seq + channels + csum
  localparam logic [15:0] ADC_FRAME_HEADER = 16'hA5A5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } pack_state_t;

  // One buffered frame; ch[0] holds CH1, ch[NUM_CH-1] holds CH8.
  typedef struct packed {
    logic [15:0]                   seq;
    logic [NUM_CH-1:0][15:0]       ch;
    logic [15:0]                   csum;
  } frame_t;

  // 16-bit wrap-around sum of the sequence number and all channel words.
  // The header is deliberately not part of the sum.
  function automatic logic [15:0] frame_csum(input logic [15:0]             seq,
                                             input logic [NUM_CH-1:0][15:0] ch);
    logic [15:0] sum;
    sum = seq;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = sum + ch[i];
    end
    return sum;
  endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// Output word stream of the frame packer toward the host link.
//
// Handshake: a word transfers on every sys_clk edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data and out_last
// stay unchanged until that transfer happens (except on clear or reset,
// which abort the frame). out_ready may change freely and never depends on
// out_valid at the master side.
interface adc_frame_packer_if;
  import adc_pkg::*;

  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/adc_frame_fifo.sv
// Two-entry synchronous FIFO of frame records. A push while full is accepted
// only when a pop happens in the same cycle (the pop frees the slot first).
module adc_frame_fifo
  import adc_pkg::*;
(
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  frame_t     push_data,
  input  logic       pop,
  output frame_t     head,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  frame_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents are don't-care until counted as valid.
  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping, cleared by reset or packer clear.
  always_ff @(posedge sys_clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs each completed 8-channel ADC conversion into an 11-word stream:
// header, sequence number, CH1..CH8, checksum. Conversions are detected on
// the synchronized rising edge of adc_read_done, buffered two deep, and
// dropped (and counted) when the buffer has no room.
module adc_frame_packer
  import adc_pkg::*;
(
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       pack_en,
  input  logic                       adc_read_done,
  input  logic [15:0]                adc_ch1_data_in,
  input  logic [15:0]                adc_ch2_data_in,
  input  logic [15:0]                adc_ch3_data_in,
  input  logic [15:0]                adc_ch4_data_in,
  input  logic [15:0]                adc_ch5_data_in,
  input  logic [15:0]                adc_ch6_data_in,
  input  logic [15:0]                adc_ch7_data_in,
  input  logic [15:0]                adc_ch8_data_in,
  adc_frame_packer_if.master         out_if,
  output logic [15:0]                drop_cnt,
  output logic                       frame_active,
  output pack_state_t                dbg_state
);

  logic                    done_sync1;
  logic                    done_sync2;
  logic                    done_hist;
  logic                    cap_pulse;
  logic [15:0]             seq_q;
  logic [NUM_CH-1:0][15:0] ch_vec;
  frame_t                  cap_entry;
  frame_t                  head;
  logic [1:0]              fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    drop;
  pack_state_t             state_q;
  pack_state_t             state_d;
  logic [2:0]              ch_idx_q;
  logic [2:0]              ch_idx_d;
  logic [15:0]             data_c;
  logic                    valid_c;
  logic                    last_c;

  // Two-flop synchronizer plus edge history for the done level.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      done_sync1 <= 1'b0;
      done_sync2 <= 1'b0;
      done_hist  <= 1'b0;
    end else begin
      done_sync1 <= adc_read_done;
      done_sync2 <= done_sync1;
      done_hist  <= done_sync2;
    end
  end

  // One pulse per low-to-high transition; suppressed while the packer is off.
  assign cap_pulse = pack_en && done_sync2 && !done_hist;

  assign ch_vec[0] = adc_ch1_data_in;
  assign ch_vec[1] = adc_ch2_data_in;
  assign ch_vec[2] = adc_ch3_data_in;
  assign ch_vec[3] = adc_ch4_data_in;
  assign ch_vec[4] = adc_ch5_data_in;
  assign ch_vec[5] = adc_ch6_data_in;
  assign ch_vec[6] = adc_ch7_data_in;
  assign ch_vec[7] = adc_ch8_data_in;

  // Snapshot record: checksum is computed once here and stored with the frame.
  always_comb begin
    cap_entry      = '0;
    cap_entry.seq  = seq_q;
    cap_entry.ch   = ch_vec;
    cap_entry.csum = frame_csum(seq_q, ch_vec);
  end

  // A frame leaves the buffer when its checksum word is accepted. That pop
  // frees a slot in the same cycle, so a simultaneous capture is never dropped.
  assign pop  = (state_q == ST_CSUM) && out_if.out_ready;
  assign push = cap_pulse && (!fifo_full || pop);
  assign drop = cap_pulse && fifo_full && !pop;

  adc_frame_fifo u_fifo (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .clear     (!pack_en),
    .push      (push),
    .push_data (cap_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequence number advances on every capture attempt, dropped or not, so the
  // sink can see the gap left by a dropped frame.
  always_ff @(posedge sys_clk) begin
    if (!rst_n || !pack_en) begin
      seq_q <= 16'h0000;
    end else if (cap_pulse) begin
      seq_q <= seq_q + 16'h0001;
    end
  end

  // Saturating drop counter; survives a packer clear, only reset zeroes it.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      drop_cnt <= 16'h0000;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'h0001;
    end
  end

  // Output FSM state register; a packer clear aborts any frame in flight.
  always_ff @(posedge sys_clk) begin
    if (!rst_n || !pack_en) begin
      state_q  <= ST_IDLE;
      ch_idx_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
    end
  end

  // Next-state and word selection; every state advances only on a transfer.
  always_comb begin
    state_d  = state_q;
    ch_idx_d = ch_idx_q;
    valid_c  = 1'b0;
    last_c   = 1'b0;
    data_c   = 16'h0000;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        valid_c = 1'b1;
        data_c  = ADC_FRAME_HEADER;
        if (out_if.out_ready) begin
          state_d = ST_SEQ;
        end
      end
      ST_SEQ: begin
        valid_c = 1'b1;
        data_c  = head.seq;
        if (out_if.out_ready) begin
          state_d  = ST_DATA;
          ch_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        valid_c = 1'b1;
        data_c  = head.ch[ch_idx_q];
        if (out_if.out_ready) begin
          if (ch_idx_q == 3'(NUM_CH - 1)) begin
            state_d = ST_CSUM;
          end else begin
            ch_idx_d = ch_idx_q + 3'd1;
          end
        end
      end
      ST_CSUM: begin
        valid_c = 1'b1;
        last_c  = 1'b1;
        data_c  = head.csum;
        if (out_if.out_ready) begin
          // Occupancy after this pop (plus any same-cycle capture) decides
          // whether the next frame starts immediately.
          if ((fifo_count > 2'd1) || push) begin
            state_d = ST_HDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ch_idx_d = 3'd0;
      end
    endcase
  end

  // Outputs derive only from registered state and the buffer head, which does
  // not move until the checksum is accepted, so a stalled word holds steady.
  assign out_if.out_valid = valid_c;
  assign out_if.out_last  = last_c;
  assign out_if.out_data  = data_c;
  assign frame_active     = (state_q != ST_IDLE);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Self-checking bench for adc_frame_packer: expected stream words are queued
// when a conversion is driven and compared as the sink accepts them.
module tb_adc_frame_packer;
  import adc_pkg::*;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst_n;
  logic        pack_en;
  logic        adc_read_done;
  logic [15:0] ch_in [NUM_CH];
  logic [15:0] drop_cnt;
  logic        frame_active;
  pack_state_t dbg_state;

  adc_frame_packer_if bus ();

  adc_frame_packer dut (
    .sys_clk         (sys_clk),
    .rst_n           (rst_n),
    .pack_en         (pack_en),
    .adc_read_done   (adc_read_done),
    .adc_ch1_data_in (ch_in[0]),
    .adc_ch2_data_in (ch_in[1]),
    .adc_ch3_data_in (ch_in[2]),
    .adc_ch4_data_in (ch_in[3]),
    .adc_ch5_data_in (ch_in[4]),
    .adc_ch6_data_in (ch_in[5]),
    .adc_ch7_data_in (ch_in[6]),
    .adc_ch8_data_in (ch_in[7]),
    .out_if          (bus.master),
    .drop_cnt        (drop_cnt),
    .frame_active    (frame_active),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks      = 0;
  int          errors      = 0;
  int          extra_words = 0;
  logic [15:0] m_seq;
  logic [16:0] exp_q [$];   // {last, data}
  logic        stall_q     = 1'b0;
  logic [16:0] stall_word  = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of one emitted frame built from the current channel inputs.
  task automatic queue_frame(input logic [15:0] seq);
    logic [15:0] csum;
    csum = seq;
    exp_q.push_back({1'b0, 16'hA5A5});
    exp_q.push_back({1'b0, seq});
    for (int i = 0; i < NUM_CH; i++) begin
      exp_q.push_back({1'b0, ch_in[i]});
      csum = csum + ch_in[i];
    end
    exp_q.push_back({1'b1, csum});
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_channels(input logic [15:0] base, input bit all_ones);
    for (int i = 0; i < NUM_CH; i++) begin
      ch_in[i] = all_ones ? 16'hFFFF : base + 16'(i);
    end
  endtask

  task automatic send_frame(input bit captured);
    if (captured) queue_frame(m_seq);
    m_seq = m_seq + 16'h0001;
    adc_read_done = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    adc_read_done = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_drain(output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge sys_clk);
      n++;
    end
    if (exp_q.size() != 0) check_val("drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    logic [16:0] w;
    if (stall_q && bus.out_valid && rst_n && pack_en)
      check_val("stall_hold", {bus.out_last, bus.out_data}, stall_word);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        extra_words++;
        $display("unexpected word %h last=%b at %0t", bus.out_data, bus.out_last, $time);
      end else begin
        w = exp_q.pop_front();
        check_val("word", {bus.out_last, bus.out_data}, w);
      end
    end
    stall_q    = bus.out_valid && !bus.out_ready;
    stall_word = {bus.out_last, bus.out_data};
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0; pack_en = 1'b1; adc_read_done = 1'b0; bus.out_ready = 1'b1;
    m_seq = 16'h0000;
    set_channels(16'h0000, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1;
    check_val("rst_valid",  bus.out_valid, 0);
    check_val("rst_last",   bus.out_last, 0);
    check_val("rst_data",   bus.out_data, 0);
    check_val("rst_drop",   drop_cnt, 0);
    check_val("rst_active", frame_active, 0);
    check_val("rst_state",  32'(dbg_state), 0);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Single frame: latency, held done gives one capture only.
    set_channels(16'h0001, 1'b0);
    queue_frame(m_seq);
    m_seq = m_seq + 16'h0001;
    adc_read_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge sys_clk); #1;
      check_val("lat_valid_low", bus.out_valid, 0);
    end
    @(posedge sys_clk); #1;
    check_val("lat_valid_k3", bus.out_valid, 1);
    check_val("lat_active", frame_active, 1);
    wait_drain(n);
    repeat (6) @(posedge sys_clk);
    #1;
    adc_read_done = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;

    // Backpressure 1-0-0-1.
    bus.out_ready = 1'b0;
    send_frame(1'b1);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      bus.out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      @(posedge sys_clk); #1;
    end
    check_val("bp_drained", exp_q.size(), 0);
    bus.out_ready = 1'b1;

    // Clear, then overflow with three captures.
    pack_en = 1'b0;
    @(posedge sys_clk); #1;
    m_seq = 16'h0000;
    pack_en = 1'b1;
    bus.out_ready = 1'b0;
    set_channels(16'h0010, 1'b0);
    send_frame(1'b1);
    set_channels(16'h0020, 1'b0);
    send_frame(1'b1);
    set_channels(16'h0030, 1'b0);
    send_frame(1'b0);
    check_val("ovf_drop", drop_cnt, 1);
    bus.out_ready = 1'b1;
    wait_drain(n);
    check_val("ovf_b2b_cycles", n, 22);

    // Checksum wrap: seq 3, all channels FFFF.
    set_channels(16'h0000, 1'b1);
    send_frame(1'b1);
    wait_drain(n);

    // Capture lands on the same edge as the checksum acceptance of a full buffer.
    bus.out_ready = 1'b0;
    set_channels(16'h0100, 1'b0);
    send_frame(1'b1);
    set_channels(16'h0110, 1'b0);
    send_frame(1'b1);
    check_val("sim_full_drop", drop_cnt, 1);
    bus.out_ready = 1'b1;
    fork
      begin
        repeat (8) @(posedge sys_clk);
        #1;
        set_channels(16'h0200, 1'b0);
        queue_frame(m_seq);
        m_seq = m_seq + 16'h0001;
        adc_read_done = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        adc_read_done = 1'b0;
      end
    join_none
    wait_drain(n);
    check_val("sim_b2b_cycles", n, 33);
    check_val("sim_drop", drop_cnt, 1);
    repeat (4) @(posedge sys_clk);
    #1;

    // Clear mid-frame.
    bus.out_ready = 1'b0;
    set_channels(16'h0300, 1'b0);
    send_frame(1'b1);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    check_val("pre_clr_state", 32'(dbg_state), 3);
    pack_en = 1'b0;
    @(posedge sys_clk); #1;
    check_val("clr_valid", bus.out_valid, 0);
    check_val("clr_active", frame_active, 0);
    check_val("clr_drop_kept", drop_cnt, 1);
    exp_q.delete();
    m_seq = 16'h0000;
    pack_en = 1'b1;
    @(posedge sys_clk); #1;
    set_channels(16'h0400, 1'b0);
    send_frame(1'b1);
    wait_drain(n);

    // Reset mid-frame.
    bus.out_ready = 1'b0;
    set_channels(16'h0500, 1'b0);
    send_frame(1'b1);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    rst_n = 1'b0;
    @(posedge sys_clk); #1;
    check_val("mrst_valid",  bus.out_valid, 0);
    check_val("mrst_last",   bus.out_last, 0);
    check_val("mrst_data",   bus.out_data, 0);
    check_val("mrst_drop",   drop_cnt, 0);
    check_val("mrst_active", frame_active, 0);
    exp_q.delete();
    m_seq = 16'h0000;
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    set_channels(16'h0600, 1'b0);
    send_frame(1'b1);
    wait_drain(n);

    repeat (5) @(posedge sys_clk);
    #1;
    check_val("extra_words", extra_words, 0);
    check_val("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_frame_packer.md
# adc_frame_packer

Downstream of the parallel ADC capture stage. Detects each completed 8-channel conversion through the `adc_read_done` handshake and snapshots the eight channel words into a 2-frame buffer. Each buffered frame is then emitted as an 11-word, 16-bit valid/ready stream toward the host link: header, sequence number, CH1..CH8, checksum. When the buffer is full, new frames are dropped and counted.

## Interface
- `NUM_CH`, 8, channels per frame; fixed at 8 in this revision.
- `HEADER`, 16'hA5A5, first word of every frame.
- `sys_clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `pack_en`  in  1  packer enable; low acts as a synchronous clear.
- `adc_read_done`  in  1  level from the capture stage; high once all 8 channels are read.
- `adc_ch1_data_in` .. `adc_ch8_data_in`  in  16 each  channel words; stable while `adc_read_done` is high.
- `out_data`  out  16  stream word.
- `out_valid`  out  1  `out_data` is valid.
- `out_last`  out  1  high on the checksum word.
- `out_ready`  in  1  sink accepts the word when `out_valid && out_ready`.
- `drop_cnt`  out  16  frames dropped on a full buffer; saturates at 16'hFFFF.
- `frame_active`  out  1  high while the FSM is not IDLE.

## Operation
- **Done synchronizer.** `adc_read_done` passes through a 2-flop synchronizer. A rising edge on the synchronized level gives a 1-cycle `cap_pulse`.
- **Capture on `cap_pulse`.**
  - Buffer not full: write {seq, ch1..ch8, csum} into the buffer.
  - Buffer full: discard the frame and increment `drop_cnt`.
  - In both cases `seq` increments (16-bit wrap), so the sink sees gaps in the sequence.
- **Checksum.** `csum` = 16-bit wrap sum of `seq` and ch1..ch8. The header is excluded. It is computed at capture and stored with the frame.
- **Buffer.** 2 entries, with `count` of 0..2.
  - Pop occurs on acceptance of the word with `out_last`.
  - Capture and pop in the same cycle: the pop is applied first, so capture succeeds even when `count`==2. `count` is unchanged.
- **FSM states.**
  - IDLE: to HDR when `count`>0.
  - HDR: emits `HEADER`.
  - SEQ: emits the stored `seq`.
  - DATA: `ch_idx` runs 0..7 and emits CH1..CH8.
  - CSUM: emits the checksum with `out_last`=1.
  - Every state advances only on `out_valid && out_ready`.
  - CSUM accepted: go to HDR if `count`-after-pop > 0, otherwise IDLE. Frames stream back-to-back with no idle cycle.
- **Output register.** `out_valid` is high in HDR, SEQ, DATA and CSUM. `out_data` and `out_last` are held stable while `out_valid && !out_ready`.
- **`pack_en` low.** Synchronous clear: buffer emptied, `seq`=0, FSM to IDLE, `cap_pulse` suppressed.
  - A frame in progress is aborted with no `out_last`. This is documented behaviour; the sink resynchronizes on `HEADER`.
  - `drop_cnt` is kept; only `rst_n` clears it.
- **Reset (`rst_n`=0 at a clock edge).** Clears everything, including both synchronizer flops and the edge-detect history.
  - Outputs: `out_valid`=0, `out_last`=0, `out_data`=0, `drop_cnt`=0, `frame_active`=0.
  - Internal: `seq`=0, `count`=0.

## Timing
- **Capture latency.** `adc_read_done` first sampled high at edge k:
  - sync1 high after k, sync2 high after k+1.
  - `cap_pulse` high in the cycle after k+1; capture at k+2.
  - FSM leaves IDLE at k+3; `out_valid` high from k+3.
- **Frame length.** 11 accepted words. With `out_ready` tied high, a frame occupies exactly 11 cycles.
- **One capture per done.** `adc_read_done` held high produces a single capture. A new capture needs a low-then-high transition on the synchronized level, at least 1 sys_clk low after sync.
- **Throughput.** One word per cycle.
- **Counter wrap.** `seq` wraps FFFF→0000; `drop_cnt` holds at FFFF.

## Structure
- **Shared package `adc_pkg`:**
  - `NUM_CH`.
  - `FRAME_WORDS` = 11.
  - `ADC_FRAME_HEADER` = 16'hA5A5.
  - FSM state enum (IDLE, HDR, SEQ, DATA, CSUM).
  - Frame-entry record type {seq, ch[8], csum}.
- **Sub-module `adc_frame_fifo`.** 2-entry synchronous FIFO of frame records. Supports simultaneous push/pop and provides `count`, `full` and `empty`.
- **Top.** Synchronizer, checksum adder, `seq`/`drop_cnt` counters, output FSM.

## Test plan
- **Single frame.** `out_ready`=1, ch1..ch8 = 0x0001..0x0008, one done pulse → A5A5, 0000, 0001..0008, 0024; `out_last` on word 11 only; `out_valid` first high at k+3.
- **Backpressure.** Same frame, `out_ready` toggled 1-0-0-1 repeatedly → no word lost or duplicated; `out_data` stable while stalled; same 11 words.
- **Overflow.** `out_ready`=0, three done pulses → `drop_cnt`=1. Release `out_ready` → frames with seq 0000 and 0001 emitted back-to-back; the next capture gets seq 0003.
- **Simultaneous capture and pop.** Buffer full, done edge timed so capture lands on the same cycle as CSUM acceptance → no drop, `drop_cnt` unchanged, next frame follows with no idle cycle.
- **Checksum wrap.** All channels 0xFFFF, seq 0x0003 → csum 0xFFFB.
- **Clear and reset mid-frame.**
  - `pack_en` low during DATA → `out_valid`=0 next cycle, buffer empty, `seq`=0, `drop_cnt` retained.
  - `rst_n` low mid-frame → all outputs at reset values.
